// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared constants and stage-register types for the control pipeline
package ctrl_pipe_pkg;

  // ALU operation classes produced by decode
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  // EX-stage operand sources
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int REG_IDX_W = 5;
  localparam int ALU_OP_W  = 2;

  typedef struct packed {
    logic                mem_read;
    logic                mem_to_reg;
    logic                mem_write;
    logic                alu_src;
    logic                reg_write;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  // Fields common to every stage register; an all-zero value is a bubble
  typedef struct packed {
    logic                 valid;
    ctrl_t                ctrl;
    logic [REG_IDX_W-1:0] rd;
    logic                 is_ecall;
    logic                 halt_cond;
  } stage_t;

  // ID/EX also keeps the source indices so forwarding can be resolved in EX
  typedef struct packed {
    stage_t               base;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 use_rs1;
    logic                 use_rs2;
  } idex_t;

  // True when an older stage will write the register a younger one reads
  function automatic logic rd_match(
    input logic                 valid,
    input logic                 reg_write,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] src
  );
    return valid && reg_write && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/ctrl_pipe_fwd_unit.sv
// rtl/ctrl_pipe_fwd_unit.sv - EX-stage forwarding select for one operand
module fwd_unit
  import ctrl_pipe_pkg::*;
(
  input  logic                 i_mem_valid,
  input  logic                 i_mem_reg_write,
  input  logic [REG_IDX_W-1:0] i_mem_rd,
  input  logic                 i_wb_valid,
  input  logic                 i_wb_reg_write,
  input  logic [REG_IDX_W-1:0] i_wb_rd,
  input  logic [REG_IDX_W-1:0] i_src,
  input  logic                 i_use,
  output logic [1:0]           o_sel
);

  // Youngest producer wins: EX/MEM result is newer than MEM/WB result
  always_comb begin
    o_sel = FWD_RF;
    if (i_use && rd_match(i_mem_valid, i_mem_reg_write, i_mem_rd, i_src)) begin
      o_sel = FWD_MEM;
    end else if (i_use && rd_match(i_wb_valid, i_wb_reg_write, i_wb_rd, i_src)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control stage registers, hazard detection, forwarding and halt tracking
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int HALT_REG = 17
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_id_valid,
  input  logic       i_id_mem_read,
  input  logic       i_id_mem_to_reg,
  input  logic       i_id_mem_write,
  input  logic       i_id_alu_src,
  input  logic       i_id_reg_write,
  input  logic       i_id_is_ecall,
  input  logic [1:0] i_id_alu_op,
  input  logic       i_id_halt_cond,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic [4:0] i_id_rd,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic       i_flush_id,
  output logic       o_stall,
  output logic       o_ex_alu_src,
  output logic [1:0] o_ex_alu_op,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic       o_mem_mem_read,
  output logic       o_mem_mem_write,
  output logic       o_wb_mem_to_reg,
  output logic       o_wb_reg_write,
  output logic [4:0] o_wb_rd,
  output logic       o_is_halted
);

  localparam logic [REG_IDX_W-1:0] HALT_IDX = REG_IDX_W'(HALT_REG);

  idex_t  r_idex;
  stage_t r_exmem;
  stage_t r_memwb;
  logic   r_halt_pending;
  logic   r_is_halted;

  idex_t  w_idex_next;
  logic   w_load_use;
  logic   w_ecall_haz;
  logic   w_stall;
  logic   w_unused_bits;

  // A load in EX cannot feed an ID consumer in time
  assign w_load_use = i_id_valid && r_idex.base.valid && r_idex.base.ctrl.mem_read
                   && (r_idex.base.rd != '0)
                   && ((i_id_use_rs1 && (i_id_rs1 == r_idex.base.rd))
                    || (i_id_use_rs2 && (i_id_rs2 == r_idex.base.rd)));

  // The halt condition is evaluated from x17 in ID, so any pending x17 write must land first
  assign w_ecall_haz = i_id_valid && i_id_is_ecall
                    && ((r_idex.base.valid && r_idex.base.ctrl.reg_write && (r_idex.base.rd == HALT_IDX))
                     || (r_exmem.valid && r_exmem.ctrl.mem_read && (r_exmem.rd == HALT_IDX)));

  // A flushed or post-halt ID slot is discarded anyway, so holding it is pointless
  assign w_stall = (w_load_use || w_ecall_haz) && !i_flush_id && !r_halt_pending;

  // Select what enters ID/EX: a bubble unless a live, unstalled instruction is present
  always_comb begin
    w_idex_next = '0;
    if (!(i_flush_id || r_halt_pending || !i_id_valid || w_stall)) begin
      w_idex_next.base.valid           = 1'b1;
      w_idex_next.base.ctrl.mem_read   = i_id_mem_read;
      w_idex_next.base.ctrl.mem_to_reg = i_id_mem_to_reg;
      w_idex_next.base.ctrl.mem_write  = i_id_mem_write;
      w_idex_next.base.ctrl.alu_src    = i_id_alu_src;
      w_idex_next.base.ctrl.reg_write  = i_id_reg_write;
      w_idex_next.base.ctrl.alu_op     = i_id_alu_op;
      w_idex_next.base.rd              = i_id_rd;
      w_idex_next.base.is_ecall        = i_id_is_ecall;
      w_idex_next.base.halt_cond       = i_id_halt_cond;
      w_idex_next.rs1                  = i_id_rs1;
      w_idex_next.rs2                  = i_id_rs2;
      w_idex_next.use_rs1              = i_id_use_rs1;
      w_idex_next.use_rs2              = i_id_use_rs2;
    end
  end

  // Stage registers always advance; halt state is sticky until reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idex         <= '0;
      r_exmem        <= '0;
      r_memwb        <= '0;
      r_halt_pending <= 1'b0;
      r_is_halted    <= 1'b0;
    end else begin
      r_idex  <= w_idex_next;
      r_exmem <= r_idex.base;
      r_memwb <= r_exmem;
      if (w_idex_next.base.valid && w_idex_next.base.is_ecall && w_idex_next.base.halt_cond) begin
        r_halt_pending <= 1'b1;
      end
      if (r_memwb.valid && r_memwb.is_ecall && r_memwb.halt_cond) begin
        r_is_halted <= 1'b1;
      end
    end
  end

  fwd_unit u_fwd_a (
    .i_mem_valid     (r_exmem.valid),
    .i_mem_reg_write (r_exmem.ctrl.reg_write),
    .i_mem_rd        (r_exmem.rd),
    .i_wb_valid      (r_memwb.valid),
    .i_wb_reg_write  (r_memwb.ctrl.reg_write),
    .i_wb_rd         (r_memwb.rd),
    .i_src           (r_idex.rs1),
    .i_use           (r_idex.use_rs1),
    .o_sel           (o_fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_mem_valid     (r_exmem.valid),
    .i_mem_reg_write (r_exmem.ctrl.reg_write),
    .i_mem_rd        (r_exmem.rd),
    .i_wb_valid      (r_memwb.valid),
    .i_wb_reg_write  (r_memwb.ctrl.reg_write),
    .i_wb_rd         (r_memwb.rd),
    .i_src           (r_idex.rs2),
    .i_use           (r_idex.use_rs2),
    .o_sel           (o_fwd_b)
  );

  assign o_stall         = w_stall;
  assign o_ex_alu_src    = r_idex.base.ctrl.alu_src;
  assign o_ex_alu_op     = r_idex.base.ctrl.alu_op;
  assign o_mem_mem_read  = r_exmem.ctrl.mem_read;
  assign o_mem_mem_write = r_exmem.ctrl.mem_write;
  assign o_wb_mem_to_reg = r_memwb.ctrl.mem_to_reg;
  assign o_wb_reg_write  = r_memwb.ctrl.reg_write;
  assign o_wb_rd         = r_memwb.rd;
  assign o_is_halted     = r_is_halted;

  // Late-stage copies of early-stage controls are carried for completeness only
  assign w_unused_bits = ^{r_exmem, r_memwb};

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - randomized and directed checks of ctrl_pipe against a stage-slot model
module tb_ctrl_pipe;

  typedef struct packed {
    logic       v, mr, m2r, mw, as, rw;
    logic [1:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ec, hc;
  } ins_t;

  logic       clk = 1'b0;
  logic       reset;
  ins_t       din;
  logic       flush;
  logic       o_stall, o_ex_alu_src, o_mem_mem_read, o_mem_mem_write;
  logic       o_wb_mem_to_reg, o_wb_reg_write, o_is_halted;
  logic [1:0] o_ex_alu_op, o_fwd_a, o_fwd_b;
  logic [4:0] o_wb_rd;

  int total = 0;
  int bad   = 0;

  // model: instructions sitting in EX, MEM and WB, plus halt flags
  ins_t m_ex, m_mem, m_wb;
  logic m_hp, m_halted;
  logic e_stall;

  always #5 clk = ~clk;

  ctrl_pipe #(.HALT_REG(17)) dut (
    .i_clk(clk), .i_reset(reset), .i_id_valid(din.v),
    .i_id_mem_read(din.mr), .i_id_mem_to_reg(din.m2r), .i_id_mem_write(din.mw),
    .i_id_alu_src(din.as), .i_id_reg_write(din.rw), .i_id_is_ecall(din.ec),
    .i_id_alu_op(din.op), .i_id_halt_cond(din.hc),
    .i_id_rs1(din.rs1), .i_id_rs2(din.rs2), .i_id_rd(din.rd),
    .i_id_use_rs1(din.u1), .i_id_use_rs2(din.u2), .i_flush_id(flush),
    .o_stall(o_stall), .o_ex_alu_src(o_ex_alu_src), .o_ex_alu_op(o_ex_alu_op),
    .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
    .o_mem_mem_read(o_mem_mem_read), .o_mem_mem_write(o_mem_mem_write),
    .o_wb_mem_to_reg(o_wb_mem_to_reg), .o_wb_reg_write(o_wb_reg_write),
    .o_wb_rd(o_wb_rd), .o_is_halted(o_is_halted)
  );

  function automatic ins_t i_nop();
    return '0;
  endfunction
  function automatic ins_t i_lw(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t t = '0;
    t.v = 1; t.mr = 1; t.m2r = 1; t.as = 1; t.rw = 1; t.rd = rd; t.rs1 = rs1; t.u1 = 1;
    return t;
  endfunction
  function automatic ins_t i_sw(input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t t = '0;
    t.v = 1; t.mw = 1; t.as = 1; t.rs1 = rs1; t.rs2 = rs2; t.u1 = 1; t.u2 = 1;
    return t;
  endfunction
  function automatic ins_t i_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t t = '0;
    t.v = 1; t.rw = 1; t.op = 2'b10; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.u1 = 1; t.u2 = 1;
    return t;
  endfunction
  function automatic ins_t i_alui(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t t = '0;
    t.v = 1; t.rw = 1; t.as = 1; t.op = 2'b10; t.rd = rd; t.rs1 = rs1; t.u1 = 1;
    return t;
  endfunction
  function automatic ins_t i_br(input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t t = '0;
    t.v = 1; t.op = 2'b01; t.rs1 = rs1; t.rs2 = rs2; t.u1 = 1; t.u2 = 1;
    return t;
  endfunction
  function automatic ins_t i_ecall(input logic hc);
    ins_t t = '0;
    t.v = 1; t.ec = 1; t.hc = hc;
    return t;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd2;
      3:       return 5'd3;
      default: return 5'd17;
    endcase
  endfunction

  function automatic ins_t rand_ins();
    ins_t t;
    case ($urandom_range(0, 5))
      0:       t = i_lw(pick_reg(), pick_reg());
      1:       t = i_sw(pick_reg(), pick_reg());
      2:       t = i_alu(pick_reg(), pick_reg(), pick_reg());
      3:       t = i_alui(pick_reg(), pick_reg());
      4:       t = i_ecall($urandom_range(0, 15) == 0);
      default: t = i_br(pick_reg(), pick_reg());
    endcase
    if ($urandom_range(0, 7) == 0) t = i_nop();
    return t;
  endfunction

  // newest older writer of src among MEM (code 1) then WB (code 2)
  function automatic logic [1:0] exp_fwd(input logic [4:0] src, input logic use_it);
    ins_t older [2];
    older[0] = m_mem;
    older[1] = m_wb;
    if (!use_it) return 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (older[k].v && older[k].rw && older[k].rd != 0 && older[k].rd == src) return 2'(k + 1);
    end
    return 2'b00;
  endfunction

  function automatic logic exp_stall(input ins_t d, input logic fl);
    logic lu, ec;
    lu = d.v && m_ex.v && m_ex.mr && m_ex.rd != 0 &&
         ((d.u1 && d.rs1 == m_ex.rd) || (d.u2 && d.rs2 == m_ex.rd));
    ec = d.v && d.ec && ((m_ex.v && m_ex.rw && m_ex.rd == 17) ||
                         (m_mem.v && m_mem.mr && m_mem.rd == 17));
    return (lu || ec) && !fl && !m_hp;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one ID slot, let it settle, compare every output with the model
  task automatic dc(input ins_t d, input logic fl, input logic rst);
    din = d; flush = fl; reset = rst;
    #1;
    e_stall = exp_stall(d, fl);
    chk("stall",       8'(o_stall),         8'(e_stall));
    chk("ex_alu_src",  8'(o_ex_alu_src),    8'(m_ex.as));
    chk("ex_alu_op",   8'(o_ex_alu_op),     8'(m_ex.op));
    chk("fwd_a",       8'(o_fwd_a),         8'(exp_fwd(m_ex.rs1, m_ex.u1)));
    chk("fwd_b",       8'(o_fwd_b),         8'(exp_fwd(m_ex.rs2, m_ex.u2)));
    chk("mem_read",    8'(o_mem_mem_read),  8'(m_mem.mr));
    chk("mem_write",   8'(o_mem_mem_write), 8'(m_mem.mw));
    chk("wb_mem2reg",  8'(o_wb_mem_to_reg), 8'(m_wb.m2r));
    chk("wb_regwrite", 8'(o_wb_reg_write),  8'(m_wb.rw));
    chk("wb_rd",       8'(o_wb_rd),         8'(m_wb.rd));
    chk("is_halted",   8'(o_is_halted),     8'(m_halted));
  endtask

  // advance one clock and move the model's instructions one slot older
  task automatic tick();
    ins_t nx;
    @(posedge clk);
    if (reset) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_hp = 0; m_halted = 0;
    end else begin
      if (m_wb.v && m_wb.ec && m_wb.hc) m_halted = 1;
      nx = (flush || m_hp || !din.v || e_stall) ? ins_t'('0) : din;
      if (nx.v && nx.ec && nx.hc) m_hp = 1;
      m_wb = m_mem; m_mem = m_ex; m_ex = nx;
    end
    @(negedge clk);
  endtask

  initial begin
    ins_t cur;
    din = '0; flush = 0; reset = 1;
    m_ex = '0; m_mem = '0; m_wb = '0; m_hp = 0; m_halted = 0; e_stall = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);

    // first cycle after reset: everything zero
    dc(i_nop(), 0, 0);
    chk("rst_halted", 8'(o_is_halted), 8'd0);
    tick();

    // lw x5; add x6,x5,x7 : one stall, bubble in EX, then MEM/WB forward
    dc(i_lw(5, 1), 0, 0); tick();
    dc(i_alu(6, 5, 7), 0, 0); chk("lu_stall", 8'(o_stall), 8'd1); tick();
    dc(i_alu(6, 5, 7), 0, 0); chk("lu_stall_once", 8'(o_stall), 8'd0);
    chk("lu_bubble_op", 8'(o_ex_alu_op), 8'd0); tick();
    dc(i_nop(), 0, 0); chk("lu_fwd_a", 8'(o_fwd_a), 8'd2); tick();

    // back-to-back dependency forwards from EX/MEM on both operands
    dc(i_alu(5, 1, 2), 0, 0); tick();
    dc(i_alu(6, 5, 5), 0, 0); chk("b2b_nostall", 8'(o_stall), 8'd0); tick();
    dc(i_nop(), 0, 0); chk("b2b_fwd_a", 8'(o_fwd_a), 8'd1);
    chk("b2b_fwd_b", 8'(o_fwd_b), 8'd1); tick();

    // one independent instruction between -> MEM/WB forward
    dc(i_alu(5, 1, 2), 0, 0); tick();
    dc(i_alu(8, 1, 2), 0, 0); tick();
    dc(i_alu(6, 5, 5), 0, 0); tick();
    dc(i_nop(), 0, 0); chk("gap_fwd_a", 8'(o_fwd_a), 8'd2);
    chk("gap_fwd_b", 8'(o_fwd_b), 8'd2); tick();

    // x0 never forwards
    dc(i_alu(0, 1, 2), 0, 0); tick();
    dc(i_alu(6, 0, 0), 0, 0); tick();
    dc(i_nop(), 0, 0); chk("x0_fwd_a", 8'(o_fwd_a), 8'd0);
    chk("x0_fwd_b", 8'(o_fwd_b), 8'd0); tick();

    // load-use with flush: no stall, bubble enters EX
    dc(i_lw(5, 1), 0, 0); tick();
    dc(i_alu(6, 5, 0), 1, 0); chk("flush_nostall", 8'(o_stall), 8'd0); tick();
    dc(i_nop(), 0, 0); chk("flush_bubble_op", 8'(o_ex_alu_op), 8'd0);
    chk("flush_bubble_src", 8'(o_ex_alu_src), 8'd0); tick();

    // ecall without halt flows through with no writes
    dc(i_ecall(0), 0, 0); tick();
    for (int c = 1; c <= 5; c++) begin
      dc(i_nop(), 0, 0);
      chk("ecall0_rw", 8'(o_wb_reg_write), 8'd0);
      chk("ecall0_halt", 8'(o_is_halted), 8'd0);
      tick();
    end

    // randomized traffic; a stalled instruction is re-presented like a held IF/ID
    cur = rand_ins();
    for (int n = 0; n < 600; n++) begin
      logic fl, rs;
      fl = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 59) == 0);
      dc(cur, fl, rs);
      if (!e_stall || fl || rs) cur = rand_ins();
      tick();
    end

    // halting ecall after addi x17: one stall, halt 4 cycles after ecall leaves ID
    dc(i_nop(), 0, 1); tick();
    dc(i_nop(), 0, 0); tick();
    dc(i_alui(17, 0), 0, 0); tick();
    dc(i_ecall(1), 0, 0); chk("ecall_stall", 8'(o_stall), 8'd1); tick();
    dc(i_ecall(1), 0, 0); chk("ecall_stall_once", 8'(o_stall), 8'd0); tick();
    for (int c = 1; c <= 7; c++) begin
      dc((c % 2 == 1) ? i_sw(1, 2) : i_alu(3, 1, 2), 0, 0);
      chk("young_mw", 8'(o_mem_mem_write), 8'd0);
      if (c >= 2) chk("young_rw", 8'(o_wb_reg_write), 8'd0);
      if (c == 3) chk("halt_not_yet", 8'(o_is_halted), 8'd0);
      if (c >= 4) chk("halt_set", 8'(o_is_halted), 8'd1);
      tick();
    end

    // reset while halted clears everything in one edge
    dc(i_alu(3, 1, 2), 0, 1); tick();
    dc(i_nop(), 0, 0);
    chk("rst_clears_halt", 8'(o_is_halted), 8'd0);
    chk("rst_wb_rw", 8'(o_wb_reg_write), 8'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the decode control bundle for the 5-stage pipelined RV32I core.
- Takes per-instruction control signals produced in ID and carries them through the ID/EX, EX/MEM and MEM/WB stage registers, presenting each control to the stage that uses it.
- Detects load-use and ecall hazards (stall/bubble), generates EX-stage forwarding selects, and raises the sticky halt flag when a halting ecall retires.

Parameters:
- HALT_REG, 17, register index read by ecall for the halt check; hazard-checked.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_is_ecall  in  1 each  decode controls.
- id_alu_op  in  2  decode ALU op class.
- id_halt_cond  in  1  datapath-evaluated x17==10, valid when id_is_ecall.
- id_rs1, id_rs2, id_rd  in  5 each  ID register indices.
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2.
- flush_id  in  1  squash the ID instruction (branch redirect from EX).
- stall  out  1  combinational; hold PC and IF/ID.
- ex_alu_src  out  1; ex_alu_op  out  2.
- fwd_a, fwd_b  out  2 each  00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- mem_mem_read, mem_mem_write  out  1 each.
- wb_mem_to_reg, wb_reg_write  out  1 each; wb_rd  out  5.
- is_halted  out  1  sticky halt.

Behaviour:
- Stage registers (ID/EX, EX/MEM, MEM/WB) each hold a valid bit, the full control bundle, rd, is_ecall and halt_cond. ID/EX additionally holds rs1/rs2 and the use bits.
- Reset (sync): all valid bits and all stored controls go to 0, and halt_pending and is_halted go to 0. Every output is 0 in the first cycle after reset.
- Bubble: valid=0 with every control 0. Outputs are driven from the stored fields, which are already zero for bubbles.
- Advance: EX/MEM<=ID/EX and MEM/WB<=EX/MEM every cycle. Only the ID/EX input is selected.
- ID/EX input priority, highest first:
  1. reset.
  2. flush_id, or halt_pending, or !id_valid: bubble.
  3. stall: bubble. IF/ID is held externally.
  4. Otherwise latch the ID bundle.
- Load-use stall: id_valid && ex_valid && ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- Ecall stall: id_valid && id_is_ecall && ((ex_valid && ex_reg_write && ex_rd==HALT_REG) || (mem_valid && mem_mem_read && mem_rd==HALT_REG)).
- stall = (load-use || ecall) && !flush_id && !halt_pending. Each stall lasts exactly 1 cycle per hazard; ecall behind a load to x17 stalls 2 cycles.
- Forwarding for A (B identical with rs2):
  - 01 if mem_valid && mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1 && ex_use_rs1.
  - Else 10 if the same condition holds for the WB stage.
  - Else 00.
  - EX/MEM has priority over MEM/WB. rd==0 never forwards. Same-cycle WB-to-ID write-through is the register file's job.
- Halt:
  - When a valid ecall with halt_cond=1 enters ID/EX, set halt_pending. All later ID instructions become bubbles, so no younger instruction executes.
  - When MEM/WB holds a valid ecall with halt_cond=1, is_halted goes to 1 on the next edge. It stays 1 until reset.
  - Ecall with halt_cond=0 flows through as a no-op (reg_write=0, mem_write=0).
- Reset mid-operation clears everything in one edge, including halt state.

Decomposition:
- Shared package/include (alongside opcodes.v):
  - alu_op class constants 2'b00 add, 2'b01 branch, 2'b10 funct-decoded.
  - Forward-select constants FWD_RF/FWD_MEM/FWD_WB.
  - Control bundle field widths.
- One natural sub-module: fwd_unit, a combinational forwarding select instantiated once for each operand.
- Hazard logic and stage registers stay in ctrl_pipe.

Test Plan:
- lw x5 then add x6,x5,x7 back-to-back -> stall=1 for 1 cycle, one bubble in EX (ex_alu_op=0), then fwd_a=10 for the add.
- add x5,..; sub x6,x5,x5 -> no stall, fwd_a=01 and fwd_b=01. With one independent instruction between -> fwd=10. With rd=x0 -> fwd=00.
- addi x17,x0,10; ecall (halt_cond=1) -> 1-cycle ecall stall. is_halted=1 exactly 4 cycles after the ecall leaves ID. Younger instructions never show wb_reg_write/mem_mem_write.
- Load-use hazard with flush_id=1 in the same cycle -> stall=0, bubble enters ID/EX.
- Ecall with halt_cond=0 -> passes to WB with all writes 0, is_halted stays 0.
- reset asserted while is_halted=1 and pipeline full -> next cycle all outputs 0, is_halted=0.
